// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: latches two WIDTH-bit operands and an opcode,
// then drives a 1-bit ALU slice LSB first, rippling the carry through a flop
// and collecting result bits into a shift register.

// 1-bit ALU slice: c selects pass a / a+b+cin / a AND b / NOT a.
module alu (
  output logic       out,
  output logic       cout,
  input  logic [1:0] c,
  input  logic       a,
  input  logic       b,
  input  logic       cin
);

  // Slice function; cout is the full-adder carry regardless of c
  always_comb begin
    out  = a;
    cout = (a & b) | (cin & (a ^ b));
    case (c)
      2'b00:   out = a;
      2'b01:   out = a ^ b ^ cin;
      2'b10:   out = a & b;
      default: out = ~a;
    endcase
  end

endmodule

module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             alu_out;
  logic             alu_cout;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  alu u_alu (
    .out  (alu_out),
    .cout (alu_cout),
    .c    (op_q),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result publication
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      op_q      <= 2'b00;
      carry_q   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            op_q    <= op;
            r_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh    <= {alu_out, r_sh[WIDTH-1:1]};
          carry_q <= alu_cout;
          cnt     <= cnt + CNT_W'(1);
          // Publish only the complete word so result never shows partials
          if (last_bit) begin
            result    <= {alu_out, r_sh[WIDTH-1:1]};
            carry_out <= (op_q == 2'b01) & alu_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl at WIDTH=8.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;

  int n_checks = 0;
  int n_errors = 0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation; checks latency, busy length, result, carry and hold.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r,
                        input logic exp_c, input bit scramble);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(posedge clk); #1;
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;   // start edge E0
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (scramble) begin
        a_in = W'($urandom); b_in = W'($urandom); op = 2'($urandom);
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_len"}, busy_cnt, 9);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_carry"}, carry_out, exp_c);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);

    run_op("add_nc",  2'b01, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    run_op("add_rip", 2'b01, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add_msb", 2'b01, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    run_op("and",     2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op("not",     2'b11, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0);
    run_op("pass",    2'b00, 8'h77, 8'hFF, 8'h77, 1'b0, 1'b0);
    run_op("and_ff",  2'b10, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);

    // Start while busy: extra requests in SHIFT cycle 3 and in DONE are ignored
    @(posedge clk); #1;
    op = 2'b01; a_in = 8'h01; b_in = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 24; k++) begin
      start = (k == 3 || k == 9);
      op = 2'b11; a_in = 8'h00; b_in = 8'h00;
      @(negedge clk);
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_start_dones", dones, 1);
    check("busy_start_result", result, 8'h03);
    check("busy_start_idle", busy, 0);

    // Reset during SHIFT cycle 4 abandons the operation
    @(posedge clk); #1;
    op = 2'b01; a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_carry", carry_out, 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    run_op("post_rst", 2'b01, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

    // Inputs changing every cycle after the start edge
    run_op("stable", 2'b01, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run_op("stable2", 2'b01, 8'hC3, 8'h7E, 8'h41, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
